regfile_write_queue: RTL
========================

// Module: regfile_write_queue
// PURPOSE
//   Write-back queue directly upstream of the 32x32 register file. Accepts register
//   write requests over a valid/ready handshake and buffers up to DEPTH of them. It
//   drains one entry per cycle into the register-file write port, which drives the
//   enable of the addressed 32-bit register. It also forwards pending data to
//   readers, so a read never returns a value older than a queued write.
// PARAMETERS
//   DEPTH       4   queue entries (power of 2, >=2)
//   DATA_WIDTH  32  write data width
//   ADDR_WIDTH  5   register index width (32 registers)
// PORTS
//   clock      in   1           single clock, rising edge
//   reset      in   1           asynchronous, active-low; clears all state
//   in_valid   in   1           write request present
//   in_ready   out  1           queue can accept a request this cycle
//   in_reg     in   ADDR_WIDTH  destination register index
//   in_data    in   DATA_WIDTH  write data
//   wr_stall   in   1           register file cannot take a write this cycle
//   wr_enable  out  1           write strobe to the register file
//   wr_reg     out  ADDR_WIDTH  register index to write
//   wr_data    out  DATA_WIDTH  data to write
//   fwd_reg    in   ADDR_WIDTH  register index being read
//   fwd_hit    out  1           a pending entry targets fwd_reg
//   fwd_data   out  DATA_WIDTH  data of the youngest matching pending entry
//   count      out  $clog2(DEPTH)+1  number of pending entries
// BEHAVIOUR
//   - Reset (reset==0, async): head/tail pointers and count -> 0, all valid bits
//     cleared. Outputs are then in_ready=1, wr_enable=0, wr_reg=0, wr_data=0,
//     fwd_hit=0, fwd_data=0, count=0. Reset mid-operation discards pending entries.
//   - Storage is a circular buffer; head and tail pointers wrap modulo DEPTH.
//   - in_ready = (count != DEPTH), combinational from registered count only.
//   - Push: happens on a clock edge when in_valid && in_ready, and writes
//     {in_reg, in_data} at the tail.
//   - Register 0: a request with in_reg==0 is accepted (handshake completes) but is
//     not enqueued. count is unchanged.
//   - Pop: wr_enable = (count!=0) && !wr_stall, combinational. wr_reg and wr_data
//     come from the head entry. Both are forced to 0 whenever wr_enable==0.
//     The head is popped on any edge where wr_enable==1.
//   - Latency: a request accepted at edge N appears on wr_* in the cycle after
//     edge N, provided the queue was empty and wr_stall==0. There is no
//     combinational pass-through from in_* to wr_*.
//   - Simultaneous push and pop: both take effect and count is unchanged. When the
//     queue is full, in_ready==0 even if a pop is occurring in that same cycle.
//   - wr_stall==1 holds the head entry. wr_* read 0 during the stall; pushes still
//     proceed until the queue is full.
//   - Forwarding (combinational): compare fwd_reg against all valid entries. The
//     youngest (closest to tail) match wins. Same-cycle in_* is not searched.
//     fwd_reg==0 always gives fwd_hit=0. With no match, fwd_hit=0 and fwd_data=0.
//     The entry currently on wr_* still counts as pending.
//   - count = pushes minus pops. It never exceeds DEPTH and never underflows.
// TESTING
//   1. Assert reset low mid-stream with 3 entries queued -> count=0, wr_enable=0,
//      in_ready=1 immediately, without waiting for a clock edge.
//   2. Push {reg 5, 0xDEADBEEF} into an empty queue with wr_stall=0 -> next cycle
//      wr_enable=1, wr_reg=5, wr_data=0xDEADBEEF; the following cycle count=0.
//   3. With wr_stall=1, push 4 requests -> count=4, in_ready=0; a 5th in_valid is
//      not accepted. Release the stall -> 4 writes come out in order, one per cycle.
//   4. Queue {r7,0x1}, {r9,0x2}, {r7,0x3} with wr_stall=1; set fwd_reg=7 ->
//      fwd_hit=1, fwd_data=0x3. Set fwd_reg=8 -> fwd_hit=0.
//   5. Push {reg 0, 0xFFFFFFFF} -> handshake completes, count stays 0, no wr_enable.
//   6. Drive push and pop every cycle for 10 cycles with count=2 -> count stays 2,
//      pointers wrap past DEPTH, and data emerges in FIFO order.

Source files
------------

// File: rtl/regfile_write_queue.sv
// Write-back queue feeding the 32x32 register file, with read forwarding of pending writes.
// Latency: one cycle from accepted request to wr_* when empty and unstalled; no in_* to wr_* path.
// Backpressure: in_ready drops when DEPTH entries are pending; wr_stall holds the head entry.
module regfile_write_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_WIDTH-1:0]   in_reg,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    wr_stall,
    output logic                    wr_enable,
    output logic [ADDR_WIDTH-1:0]   wr_reg,
    output logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [ADDR_WIDTH-1:0]   fwd_reg,
    output logic                    fwd_hit,
    output logic [DATA_WIDTH-1:0]   fwd_data,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rreg;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [DEPTH-1:0]   vld_q, vld_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop;
    logic [PTR_W-1:0]   fwd_idx;

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign wr_enable = (count_q != '0) && !wr_stall;
    assign wr_reg    = wr_enable ? mem_q[head_q].rreg : '0;
    assign wr_data   = wr_enable ? mem_q[head_q].data : '0;
    assign count     = count_q;

    // Writes to register 0 complete the handshake but are dropped.
    assign push = in_valid && in_ready && (in_reg != '0);
    assign pop  = wr_enable;

    always_comb begin
        mem_d   = mem_q;
        vld_d   = vld_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PTR_W'(1);
        end
        if (push) begin
            mem_d[tail_q] = '{rreg: in_reg, data: in_data};
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to youngest so the youngest match is the last one kept.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if (vld_q[fwd_idx] && (mem_q[fwd_idx].rreg == fwd_reg) && (fwd_reg != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_q[fwd_idx].data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule
